muldiv_seq: RTL and testbench
=============================

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the operand and result width (any even value >= 8).
REQ-002 The block SHALL have parameter CNT_W, default $clog2(XLEN)+1, giving the iteration counter width.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  request; accepted only when ready=1.
REQ-007 op  input  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 a  input  XLEN  operand rs1.
REQ-009 b  input  XLEN  operand rs2.
REQ-010 flush  input  1  synchronous abort of the operation in flight.
REQ-011 ready  output  1  high in IDLE and DONE states.
REQ-012 busy  output  1  high in CALC and FIX states.
REQ-013 done  output  1  one-cycle pulse when result is valid.
REQ-014 result  output  XLEN  registered result; held until the next accepted start.

Function
REQ-015 FSM states SHALL be IDLE, CALC, FIX, DONE; DONE SHALL go to IDLE on the next edge unless start is accepted.
REQ-016 On an edge with start=1 and ready=1, the block SHALL latch op, a and b, clear the counter, and enter CALC (normal case) or DONE (special case).
REQ-017 start with ready=0 SHALL be ignored without altering state, operands or result.
REQ-018 Multiply SHALL be shift-add on operand magnitudes, one bit per cycle, 2*XLEN-bit product; a is signed for MUL/MULH/MULHSU, b is signed for MUL/MULH only.
REQ-019 Divide SHALL be restoring, one quotient bit per cycle, on magnitudes; signed for DIV/REM.
REQ-020 CALC SHALL last exactly XLEN cycles; then FIX for one cycle applies sign correction and selects the output word.
REQ-021 Sign rules: product negated when the operand signs differ; quotient negated when the operand signs differ; remainder takes the sign of a.
REQ-022 Output selection: MUL = product[XLEN-1:0]; MULH/MULHSU/MULHU = product[2*XLEN-1:XLEN]; DIV/DIVU = quotient; REM/REMU = remainder.
REQ-023 Normal latency: start sampled at edge k, result and done=1 SHALL be visible after edge k+XLEN+1 (XLEN+2 cycles).
REQ-024 Special cases SHALL complete directly to DONE with done visible after edge k (1 cycle): b=0 gives DIV/DIVU all-ones and REM/REMU a; DIV with a=most-negative and b=all-ones gives a; REM with the same operands gives 0.
REQ-025 done SHALL be high exactly one cycle per accepted start; start accepted in DONE SHALL begin the next operation with no idle cycle.
REQ-026 flush=1 SHALL force IDLE on that edge from any state; no done; result unchanged; flush has priority over start.
REQ-027 rst SHALL have priority over flush and start.
REQ-028 Operand inputs SHALL NOT affect an operation after it is latched.

Reset
REQ-029 On rst: state IDLE, ready=1, busy=0, done=0, result=0, counter=0, internal accumulators=0.
REQ-030 rst asserted mid-operation SHALL abandon it with no done pulse; first start after rst deassertion SHALL be accepted.

Verification
REQ-031 MUL a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB, done after exactly 34 cycles, busy high for 33 cycles.
REQ-032 MULH a=b=0x80000000 -> 0x40000000; MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF; MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE.
REQ-033 DIV a=5, b=0 -> 0xFFFFFFFF after 1 cycle; REMU a=100, b=0 -> 100; DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
REQ-034 DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; REMU a=100, b=7 -> 2.
REQ-035 Flush at CALC cycle 10 -> IDLE next edge, no done, result retains the previous value; rst mid-CALC -> all outputs at reset values.
REQ-036 start held high across DONE, and start issued while busy -> back-to-back DONE-to-CALC transition with no idle cycle; the busy-time start is ignored.

Source files
------------

// File: rtl/muldiv_seq.sv
// Sequential RV32M-style multiply/divide unit: shift-add multiply and restoring
// divide on operand magnitudes, one bit per cycle, followed by a sign-fix cycle.
module muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic            i_flush,
  output logic            o_ready,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  // state | meaning
  // IDLE  | waiting for start
  // CALC  | XLEN iterations of shift-add or restoring divide
  // FIX   | sign correction and output word selection
  // DONE  | result valid, done pulse; may accept the next start
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [2:0]        r_op;
  logic [XLEN-1:0]   r_b_mag;
  logic [2*XLEN-1:0] r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_neg_main;
  logic              r_neg_rem;
  logic [XLEN-1:0]   r_result;

  logic            w_accept;
  logic            w_is_div;
  logic            w_a_signed;
  logic            w_b_signed;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic            w_b_zero;
  logic            w_ovf;
  logic            w_special;
  logic [XLEN-1:0] w_special_res;
  logic            w_last_iter;

  assign o_ready  = (r_state == S_IDLE) || (r_state == S_DONE);
  assign o_busy   = (r_state == S_CALC) || (r_state == S_FIX);
  assign o_done   = (r_state == S_DONE);
  assign o_result = r_result;

  assign w_accept    = i_start && o_ready;
  assign w_last_iter = (r_cnt == CNT_W'(XLEN - 1));

  // Operand signedness: divides are signed when op[0]=0; MULHU is fully unsigned,
  // MULHSU has only rs1 signed.
  assign w_is_div   = i_op[2];
  assign w_a_signed = w_is_div ? ~i_op[0] : (i_op != 3'b011);
  assign w_b_signed = w_is_div ? ~i_op[0] : ~i_op[1];
  assign w_a_neg    = w_a_signed && i_a[XLEN-1];
  assign w_b_neg    = w_b_signed && i_b[XLEN-1];
  assign w_a_mag    = w_a_neg ? -i_a : i_a;
  assign w_b_mag    = w_b_neg ? -i_b : i_b;

  assign w_b_zero  = (i_b == '0);
  assign w_ovf     = w_is_div && !i_op[0]
                     && (i_a == {1'b1, {(XLEN-1){1'b0}}}) && (i_b == '1);
  assign w_special = w_is_div && (w_b_zero || w_ovf);

  always_comb begin
    w_special_res = '0;
    if (w_b_zero) begin
      w_special_res = i_op[1] ? i_a : '1;
    end else begin
      w_special_res = i_op[1] ? '0 : i_a;
    end
  end

  // Multiply step: accumulate into the upper half, shift the multiplier out the bottom.
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_next;
  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b_mag} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

  // Divide step: upper half is the partial remainder, lower half shifts dividend out
  // and quotient bits in. The trial subtract is XLEN+1 wide so its MSB is the borrow.
  logic [XLEN:0]     w_div_trial;
  logic [2*XLEN-1:0] w_div_next;
  assign w_div_trial = r_acc[2*XLEN-1:XLEN-1] - {1'b0, r_b_mag};
  assign w_div_next  = !w_div_trial[XLEN]
                       ? {w_div_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1}
                       : {r_acc[2*XLEN-2:0], 1'b0};

  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_quo_fix;
  logic [XLEN-1:0]   w_rem_fix;
  logic [XLEN-1:0]   w_fix_res;
  assign w_prod_fix = r_neg_main ? -r_acc : r_acc;
  assign w_quo_fix  = r_neg_main ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  assign w_rem_fix  = r_neg_rem ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

  always_comb begin
    w_fix_res = '0;
    case (r_op)
      3'b000:                 w_fix_res = w_prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_fix_res = w_prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_fix_res = w_quo_fix;
      default:                w_fix_res = w_rem_fix;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = w_special ? S_DONE : S_CALC;
      S_CALC: if (w_last_iter) w_next = S_FIX;
      S_FIX:  w_next = S_DONE;
      S_DONE: begin
        if (w_accept) w_next = w_special ? S_DONE : S_CALC;
        else          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (i_flush) w_next = S_IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_op       <= '0;
      r_b_mag    <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_neg_main <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_result   <= '0;
    end else if (!i_flush) begin
      if (w_accept) begin
        r_op       <= i_op;
        r_b_mag    <= w_b_mag;
        r_acc      <= {{XLEN{1'b0}}, w_a_mag};
        r_cnt      <= '0;
        r_neg_main <= w_a_neg ^ w_b_neg;
        r_neg_rem  <= w_a_neg;
        if (w_special) r_result <= w_special_res;
      end else if (r_state == S_CALC) begin
        r_acc <= r_op[2] ? w_div_next : w_mul_next;
        r_cnt <= r_cnt + CNT_W'(1);
      end else if (r_state == S_FIX) begin
        r_result <= w_fix_res;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized bench for muldiv_seq against a plain-arithmetic reference, plus
// directed latency, flush, reset and back-to-back cases.
module tb_muldiv_seq;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst, start, flush;
  logic [2:0]      op;
  logic [XLEN-1:0] a, b;
  logic            ready, busy, done;
  logic [XLEN-1:0] result;

  always #5 clk = ~clk;

  muldiv_seq #(.XLEN(XLEN)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_op(op), .i_a(a), .i_b(b),
    .i_flush(flush), .o_ready(ready), .o_busy(busy), .o_done(done), .o_result(result)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] last_res;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_special(input logic [2:0] f_op, input logic [31:0] f_a, input logic [31:0] f_b);
    if (!f_op[2]) return 1'b0;
    if (f_b == 0) return 1'b1;
    return (f_op == 3'b100 || f_op == 3'b110) && f_a == 32'h8000_0000 && f_b == 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] ref_model(input logic [2:0] f_op, input logic [31:0] f_a, input logic [31:0] f_b);
    longint sa, sb, q;
    logic [63:0] p;
    logic [31:0] ua, ub;
    sa = longint'($signed(f_a));
    sb = longint'($signed(f_b));
    ua = f_a;
    ub = f_b;
    p = '0;
    case (f_op)
      3'd0: begin p = sa * sb;               return p[31:0];  end
      3'd1: begin p = sa * sb;               return p[63:32]; end
      3'd2: begin p = sa * longint'({32'b0, f_b}); return p[63:32]; end
      3'd3: begin p = {32'b0, f_a} * {32'b0, f_b}; return p[63:32]; end
      3'd4: begin
        if (f_b == 0) return 32'hFFFF_FFFF;
        if (f_a == 32'h8000_0000 && f_b == 32'hFFFF_FFFF) return f_a;
        q = sa / sb; p = q; return p[31:0];
      end
      3'd5: return (f_b == 0) ? 32'hFFFF_FFFF : ua / ub;
      3'd6: begin
        if (f_b == 0) return f_a;
        if (f_a == 32'h8000_0000 && f_b == 32'hFFFF_FFFF) return 32'h0;
        q = sa % sb; p = q; return p[31:0];
      end
      default: return (f_b == 0) ? f_a : ua % ub;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issue one operation (caller ensures IDLE or DONE) and wait for done.
  task automatic do_op(input logic [2:0] t_op, input logic [31:0] t_a, input logic [31:0] t_b, input bit poke);
    logic [31:0] exp;
    bit spec;
    int lat, bcnt;
    exp  = ref_model(t_op, t_a, t_b);
    spec = is_special(t_op, t_a, t_b);
    chk("ready_before_start", ready, 1);
    start = 1'b1; op = t_op; a = t_a; b = t_b;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom);
    lat = 0; bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      start = (poke && lat == 5);
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk("latency", lat, spec ? 0 : XLEN + 1);
    chk("busy_cycles", bcnt, spec ? 0 : XLEN + 1);
    chk("result", result, exp);
    last_res = exp;
  endtask

  task automatic idle_step();
    @(posedge clk); #1;
    chk("done_single_pulse", done, 0);
    chk("ready_in_idle", ready, 1);
    chk("result_held", result, last_res);
  endtask

  typedef struct { logic [2:0] op; logic [31:0] a; logic [31:0] b; } vec_t;
  vec_t dir[$];

  initial begin
    int cnt;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    last_res = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    rst = 1'b0;

    dir.push_back('{3'd0, 32'd7,          32'hFFFF_FFFD});
    dir.push_back('{3'd1, 32'h8000_0000,  32'h8000_0000});
    dir.push_back('{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF});
    dir.push_back('{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF});
    dir.push_back('{3'd4, 32'd5,          32'd0});
    dir.push_back('{3'd7, 32'd100,        32'd0});
    dir.push_back('{3'd4, 32'h8000_0000,  32'hFFFF_FFFF});
    dir.push_back('{3'd6, 32'h8000_0000,  32'hFFFF_FFFF});
    dir.push_back('{3'd4, 32'hFFFF_FFF9,  32'd2});
    dir.push_back('{3'd6, 32'hFFFF_FFF9,  32'd2});
    dir.push_back('{3'd7, 32'd100,        32'd7});
    dir.push_back('{3'd5, 32'hFFFF_FFFF,  32'd3});
    foreach (dir[i]) begin
      do_op(dir[i].op, dir[i].a, dir[i].b, 1'b0);
      idle_step();
    end

    // Back-to-back from DONE, with a start pulse while busy that must be ignored.
    do_op(3'd0, 32'd1234, 32'd5678, 1'b1);
    do_op(3'd4, 32'hFFFF_FF00, 32'd7, 1'b1);
    do_op(3'd5, 32'd9, 32'd0, 1'b0);
    do_op(3'd6, 32'd77, 32'hFFFF_FFF6, 1'b0);
    idle_step();

    // Flush at CALC cycle 10.
    start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("busy_before_flush", busy, 1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_ready", ready, 1);
    chk("flush_result", result, last_res);
    cnt = 0;
    repeat (40) begin
      if (done) cnt++;
      @(posedge clk); #1;
    end
    chk("flush_no_done", cnt, 0);

    // Flush wins over start.
    start = 1'b1; flush = 1'b1; op = 3'd1; a = 32'd2; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("flush_prio_busy", busy, 0);
    chk("flush_prio_done", done, 0);

    // Reset mid-CALC.
    start = 1'b1; op = 3'd5; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_ready", ready, 1);
    chk("midrst_result", result, 0);
    last_res = '0;
    do_op(3'd7, 32'd100, 32'd7, 1'b0);
    idle_step();

    for (int i = 0; i < 150; i++) begin
      do_op(3'($urandom_range(0, 7)), pick(), pick(), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle_step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
